// File: rtl/if_pcgen.sv
// Instruction-fetch PC generator: sequential fetch, EX-stage redirects,
// misaligned-target traps, stall-time pending redirect and a redirect counter.
module if_pcgen #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [1:0]       ex_op,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_br,
  input  logic [XLEN-1:0]  ex_offset,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc4,
  output logic             flush,
  output logic             misalign,
  output logic [XLEN-1:0]  bad_addr,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic [1:0] {
    NPC_PC4  = 2'd0,
    NPC_JMP  = 2'd1,
    NPC_JMPR = 2'd2,
    NPC_BEQ  = 2'd3
  } npc_op_e;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pend_pc;
  logic             r_pend_valid;
  logic             r_flush;
  logic             r_misalign;
  logic [XLEN-1:0]  r_bad_addr;
  logic [CNT_W-1:0] r_cnt;

  npc_op_e          w_op;
  logic [XLEN-1:0]  w_sum;
  logic [XLEN-1:0]  w_tgt;
  logic [XLEN-1:0]  w_dest;
  logic [XLEN-1:0]  w_npc;
  logic [XLEN-1:0]  w_pc4;
  logic             w_req;
  logic             w_trap;

  assign w_op  = npc_op_e'(ex_op);
  assign w_sum = ex_pc + ex_offset;
  assign w_pc4 = r_pc + XLEN'(4);

  always_comb begin
    w_req = 1'b0;
    w_tgt = w_sum;
    unique case (w_op)
      NPC_JMP:  w_req = ex_valid;
      NPC_JMPR: begin
        w_req = ex_valid;
        w_tgt = {ex_offset[XLEN-1:1], 1'b0};
      end
      NPC_BEQ:  w_req = ex_valid & ex_br;
      default:  w_req = 1'b0;
    endcase
  end

  // A target with bit 1 set is not word-aligned; it becomes a trap instead.
  assign w_trap = w_req & w_tgt[1];
  assign w_dest = w_trap ? TRAP_VEC : w_tgt;

  always_comb begin
    w_npc = w_pc4;
    if (w_req)             w_npc = w_dest;
    else if (r_pend_valid) w_npc = r_pend_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
      r_flush      <= 1'b0;
      r_misalign   <= 1'b0;
      r_bad_addr   <= '0;
      r_cnt        <= '0;
    end else begin
      if (!stall) begin
        r_pc         <= w_npc;
        r_pend_valid <= 1'b0;
      end else if (w_req) begin
        r_pend_pc    <= w_dest;
        r_pend_valid <= 1'b1;
      end
      r_flush    <= w_req;
      r_misalign <= w_trap;
      if (w_trap) r_bad_addr <= w_tgt;
      if (w_req)  r_cnt      <= r_cnt + CNT_W'(1);
    end
  end

  assign pc        = r_pc;
  assign pc4       = w_pc4;
  assign flush     = r_flush;
  assign misalign  = r_misalign;
  assign bad_addr  = r_bad_addr;
  assign redir_cnt = r_cnt;

endmodule

// File: tb/tb_if_pcgen.sv
// Bench for if_pcgen: directed vector table, async-reset sequence and random
// stimulus, all checked against a queue-based fetch model.
module tb_if_pcgen;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, ex_valid, ex_br;
  logic [1:0]  ex_op;
  logic [31:0] ex_pc, ex_offset;

  logic [31:0] pc, pc4, bad_addr;
  logic        flush, misalign;
  logic [15:0] redir_cnt;

  logic [31:0] pc_b, pc4_b, bad_addr_b;
  logic        flush_b, misalign_b;
  logic [1:0]  redir_cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_pcgen #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(TRAP), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_pc(ex_pc), .ex_br(ex_br), .ex_offset(ex_offset),
    .pc(pc), .pc4(pc4), .flush(flush), .misalign(misalign),
    .bad_addr(bad_addr), .redir_cnt(redir_cnt)
  );

  if_pcgen #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(TRAP), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_pc(ex_pc), .ex_br(ex_br), .ex_offset(ex_offset),
    .pc(pc_b), .pc4(pc4_b), .flush(flush_b), .misalign(misalign_b),
    .bad_addr(bad_addr_b), .redir_cnt(redir_cnt_b)
  );

  // Reference model: pending redirect is a queue holding at most one target.
  logic [31:0] m_pc, m_bad;
  logic [31:0] m_pend[$];
  logic        m_flush, m_mis;
  int unsigned m_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_bad = 32'h0; m_flush = 1'b0; m_mis = 1'b0; m_cnt = 0;
    m_pend.delete();
  endtask

  task automatic model_edge();
    bit          req, trap;
    logic [31:0] tgt, dest;
    req = 1'b0;
    tgt = ex_pc + ex_offset;
    if (ex_valid) begin
      if (ex_op == 2'd1) req = 1'b1;
      if (ex_op == 2'd2) begin req = 1'b1; tgt = ex_offset & ~32'h1; end
      if (ex_op == 2'd3 && ex_br) req = 1'b1;
    end
    trap = req && ((tgt >> 1) % 2 == 1);
    dest = trap ? TRAP : tgt;
    if (!stall) begin
      if (req)                   m_pc = dest;
      else if (m_pend.size() > 0) m_pc = m_pend[0];
      else                       m_pc = m_pc + 4;
      m_pend.delete();
    end else if (req) begin
      m_pend.delete();
      m_pend.push_back(dest);
    end
    m_flush = req;
    m_mis   = trap;
    if (trap) m_bad = tgt;
    if (req)  m_cnt = m_cnt + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 4);
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("bad_addr", bad_addr, m_bad);
    chk("redir_cnt", {16'b0, redir_cnt}, m_cnt % 65536);
    chk("w2_pc", pc_b, m_pc);
    chk("w2_pc4", pc4_b, m_pc + 4);
    chk("w2_flush", {31'b0, flush_b}, {31'b0, m_flush});
    chk("w2_misalign", {31'b0, misalign_b}, {31'b0, m_mis});
    chk("w2_bad_addr", bad_addr_b, m_bad);
    chk("w2_redir_cnt", {30'b0, redir_cnt_b}, m_cnt % 4);
  endtask

  task automatic drive(input logic s, input logic v, input logic [1:0] op,
                       input logic [31:0] epc, input logic br, input logic [31:0] off);
    stall = s; ex_valid = v; ex_op = op; ex_pc = epc; ex_br = br; ex_offset = off;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  typedef struct {
    logic        s, v;
    logic [1:0]  op;
    logic [31:0] epc;
    logic        br;
    logic [31:0] off;
    logic [31:0] xpc;
    logic        xfl, xmis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic v, logic [1:0] op, logic [31:0] epc,
                              logic br, logic [31:0] off, logic [31:0] xpc,
                              logic xfl, logic xmis);
    vec_t r;
    r.s = s; r.v = v; r.op = op; r.epc = epc; r.br = br; r.off = off;
    r.xpc = xpc; r.xfl = xfl; r.xmis = xmis;
    return r;
  endfunction

  initial begin
    // stall valid op ex_pc br offset -> pc flush misalign
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h4,   0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h8,   0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'hC,   0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h10,  0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h8,        1, 32'h20,  32'h28,  1, 0));
    tbl.push_back(mk(0, 1, 3, 32'h8,        0, 32'h20,  32'h2C,  0, 0));
    tbl.push_back(mk(0, 1, 2, 32'h0,        0, 32'h101, 32'h100, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h104, 0, 0));
    tbl.push_back(mk(0, 1, 2, 32'h0,        0, 32'h102, TRAP,    1, 1));
    tbl.push_back(mk(1, 1, 1, 32'h30,       0, 32'h10,  32'h100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   32'h100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   32'h100, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h40,  0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h44,  0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h0,        0, 32'h80,  32'h44,  1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h0,        0, 32'h90,  32'h44,  1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h90,  0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h0,        0, 32'hA0,  32'h90,  1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0,        0, 32'hC0,  32'hC0,  1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'hC4,  0, 0));
    tbl.push_back(mk(1, 1, 2, 32'h0,        0, 32'h6,   32'hC4,  1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   TRAP,    0, 0));
    tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFF0, 0, 32'h20, 32'h10,  1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h0,        0, 32'h200, 32'h10,  1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h0,        0, 32'h200, 32'h10,  1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h200, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h80,  32'h204, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0,        0, 32'h42,  TRAP,    1, 1));

    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    model_reset();
    #2;
    chk("reset_pc", pc, 32'h0);
    chk("reset_flush", {31'b0, flush}, 32'h0);
    chk("reset_cnt", {16'b0, redir_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_model();

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].v, tbl[i].op, tbl[i].epc, tbl[i].br, tbl[i].off);
      step();
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].xpc);
      chk($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, tbl[i].xfl});
      chk($sformatf("vec%0d_misalign", i), {31'b0, misalign}, {31'b0, tbl[i].xmis});
    end

    // Asynchronous reset while a stalled redirect is pending.
    drive(1, 1, 1, 32'h0, 0, 32'h80);
    step();
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_flush", {31'b0, flush}, 32'h0);
    chk("async_rst_cnt", {16'b0, redir_cnt}, 32'h0);
    chk("async_rst_bad", bad_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step();
    chk("post_rst_pc", pc, 32'h4);

    for (int unsigned k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 9) < 3), $urandom_range(0, 1),
            2'($urandom_range(0, 3)), $urandom & ~32'h3,
            $urandom_range(0, 1), $urandom_range(0, 1) ? ($urandom & 32'hFFC) : $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_pcgen.md
IF_PCGEN -- requirements
Module: if_pcgen

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, address width. RESET_PC, default 0, PC after reset. TRAP_VEC, default 32'h0000_0100, misaligned-target handler address. CNT_W, default 16, redirect counter width.
REQ-002 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port stall, input, 1: hold PC this cycle.
REQ-005 Port ex_valid, input, 1: EX-stage control-flow fields are valid.
REQ-006 Port ex_op, input, 2: NPC_PC4=0, NPC_JMP=1, NPC_JMPR=2, NPC_BEQ=3.
REQ-007 Port ex_pc, input, XLEN: PC of the EX instruction.
REQ-008 Port ex_br, input, 1: branch condition true (ALU result).
REQ-009 Port ex_offset, input, XLEN: PC-relative offset, or absolute target for JMPR.
REQ-010 Port pc, output, XLEN: registered fetch PC.
REQ-011 Port pc4, output, XLEN: combinational pc+4.
REQ-012 Port flush, output, 1: registered pulse; squash IF/ID.
REQ-013 Port misalign, output, 1: registered pulse; misaligned target trapped.
REQ-014 Port bad_addr, output, XLEN: last misaligned target.
REQ-015 Port redir_cnt, output, CNT_W: count of accepted redirects.

Function
REQ-016 Redirect request SHALL be: ex_valid and (ex_op==JMP, or ex_op==JMPR, or ex_op==BEQ with ex_br==1); ex_op==PC4, or BEQ with ex_br==0, SHALL not redirect.
REQ-017 Target SHALL be ex_pc+ex_offset for JMP/BEQ and {ex_offset[XLEN-1:1],1'b0} for JMPR; sums SHALL wrap mod 2^XLEN.
REQ-018 Target with target[1]==1 SHALL be misaligned; this SHALL replace the redirect with a trap to TRAP_VEC.
REQ-019 Next-PC priority SHALL be: trap > current redirect > pending redirect > pc+4.
REQ-020 With stall==0, pc SHALL load the selected next PC at the next edge (latency 1 cycle).
REQ-021 With stall==1, pc SHALL hold, and a redirect or trap target SHALL be stored in a pending register with pend_valid=1; a later request during the same stall SHALL overwrite it.
REQ-022 On the first non-stalled edge with pend_valid=1 and no new request, pc SHALL load the pending target and pend_valid SHALL clear.
REQ-023 A new request on a non-stalled edge SHALL win over and clear pend_valid.
REQ-024 flush SHALL be 1 for exactly the cycle after each edge on which a request (redirect or trap) is sampled, regardless of stall.
REQ-025 misalign SHALL be 1 for the cycle after a trap is sampled, with bad_addr loading the offending target on that edge; bad_addr SHALL otherwise hold.
REQ-026 redir_cnt SHALL increment by 1 per sampled request, traps included, and SHALL wrap from all-ones to 0.
REQ-027 A request held across several stalled cycles with identical fields SHALL count and flush once per sampled edge; no deduplication is required.

Reset
REQ-028 rst==1 SHALL immediately set pc=RESET_PC, pend_valid=0, flush=0, misalign=0, bad_addr=0, redir_cnt=0, independent of clk.
REQ-029 Reset mid-stall SHALL discard any pending target; the first fetch after release SHALL be RESET_PC.
REQ-030 The first edge after rst falls SHALL apply normal rules.

Verification
REQ-031 Sequential fetch: reset, stall=0, ex_valid=0 for 4 cycles -> pc 0,4,8,C,10; flush=0.
REQ-032 Taken BEQ: ex_pc=8, ex_offset=0x20, ex_br=1 -> next pc=0x28, flush=1 for 1 cycle, redir_cnt=1; with ex_br=0, pc+4, no flush.
REQ-033 JMPR: ex_offset=0x101 -> pc=0x100; ex_offset=0x102 -> pc=TRAP_VEC, misalign=1, bad_addr=0x102.
REQ-034 Stalled redirect: stall=1 for 3 cycles, JMP target 0x40 in cycle 1 -> pc holds and flush pulses; stall drops -> pc=0x40 next edge; pend_valid=0.
REQ-035 Counter wrap: CNT_W=2, 5 redirects -> redir_cnt 1,2,3,0,1.
REQ-036 Async reset: assert rst between edges while pend_valid=1 -> pc=RESET_PC before next edge; no pending jump after release.
